sdram_req_arbiter: RTL and testbench

- Sits directly upstream of the byte-wide SDRAM controller, between the system masters and its `rd`/`we`/`ready` interface.
- Arbitrates two masters with round-robin priority:
  - port A: Z80 CPU memory slot;
  - port B: ROM loader/DMA.
- Converts each master's level req/ack handshake into the controller's rising-edge `rd`/`we` strobes.
- Sequences controller `init` after reset and latches read data so masters see stable data after `ack`.

---
 rtl/sdram_req_arbiter_if.sv | 45 ++++
 rtl/sdram_req_arbiter.sv | 102 ++++++++++
 tb/tb_sdram_req_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_req_arbiter_if.sv
// Bundle of both master req/ack ports and the SDRAM controller strobe interface.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface sdram_req_arbiter_if #(
  parameter int ADDR_W = 25
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [7:0]        a_din;
  logic [7:0]        a_dout;
  logic              a_ack;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [7:0]        b_din;
  logic [7:0]        b_dout;
  logic              b_ack;

  logic              sd_init;
  logic [ADDR_W-1:0] sd_addr;
  logic [7:0]        sd_din;
  logic [7:0]        sd_dout;
  logic              sd_rd;
  logic              sd_we;
  logic              sd_ready;

  modport slave (
    input  a_req, a_we, a_addr, a_din,
    output a_dout, a_ack,
    input  b_req, b_we, b_addr, b_din,
    output b_dout, b_ack,
    output sd_init, sd_addr, sd_din, sd_rd, sd_we,
    input  sd_dout, sd_ready
  );

  modport master (
    output a_req, a_we, a_addr, a_din,
    input  a_dout, a_ack,
    output b_req, b_we, b_addr, b_din,
    input  b_dout, b_ack,
    input  sd_init, sd_addr, sd_din, sd_rd, sd_we,
    output sd_dout, sd_ready
  );
endinterface

// File: rtl/sdram_req_arbiter.sv
// Round-robin arbiter putting a CPU port and a loader/DMA port onto one byte-wide SDRAM controller.
// Converts level req/ack handshakes into edge-sensitive rd/we strobes and sequences controller init.
module sdram_req_arbiter #(
  parameter int ADDR_W      = 25,
  parameter int INIT_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input logic                clk,
  input logic                reset_n,
  sdram_req_arbiter_if.slave bus
);
  typedef enum logic [2:0] {S_INIT, S_BOOT, S_IDLE, S_STROBE, S_HOLD, S_POLL, S_GAP} state_t;

  localparam int CNT_MAX = (INIT_CYCLES > GAP_CYCLES) ? INIT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              last_b;
  logic              cur_b;
  logic              cur_we;
  logic              grant_b;
  logic              take;
  logic              done;
  logic              strobe_on;
  logic              grant_we;
  logic [ADDR_W-1:0] grant_addr;
  logic [7:0]        grant_din;

  // cnt restarts on every state change, so it times both INIT and GAP
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? '0 : cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:   if (cnt == INIT_LAST) state_nxt = S_BOOT;
      S_BOOT:   if (bus.sd_ready) state_nxt = S_IDLE;
      S_IDLE:   if (bus.a_req || bus.b_req) state_nxt = S_STROBE;
      S_STROBE: state_nxt = S_HOLD;
      // ready only falls one edge after the controller sees the strobe, so HOLD ignores it
      S_HOLD:   state_nxt = S_POLL;
      S_POLL:   if (bus.sd_ready) state_nxt = S_GAP;
      S_GAP:    if (cnt == GAP_LAST) state_nxt = S_IDLE;
      default:  state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    grant_b     = bus.b_req && (!bus.a_req || !last_b);
    take        = (state == S_IDLE) && (bus.a_req || bus.b_req);
    done        = (state == S_POLL) && bus.sd_ready;
    grant_we    = grant_b ? bus.b_we   : bus.a_we;
    grant_addr  = grant_b ? bus.b_addr : bus.a_addr;
    grant_din   = grant_b ? bus.b_din  : bus.a_din;
    strobe_on   = (state == S_STROBE) || (state == S_HOLD) || (state == S_POLL);
    bus.sd_init = (state == S_INIT);
    bus.sd_rd   = strobe_on && !cur_we;
    bus.sd_we   = strobe_on && cur_we;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_b      <= 1'b1;
      cur_b       <= 1'b0;
      cur_we      <= 1'b0;
      bus.sd_addr <= '0;
      bus.sd_din  <= '0;
      bus.a_ack   <= 1'b0;
      bus.b_ack   <= 1'b0;
      bus.a_dout  <= '0;
      bus.b_dout  <= '0;
    end else begin
      bus.a_ack <= 1'b0;
      bus.b_ack <= 1'b0;
      if (take) begin
        last_b      <= grant_b;
        cur_b       <= grant_b;
        cur_we      <= grant_we;
        bus.sd_addr <= grant_addr;
        bus.sd_din  <= grant_din;
      end
      if (done) begin
        if (cur_b) bus.b_ack <= 1'b1;
        else       bus.a_ack <= 1'b1;
        if (!cur_we) begin
          if (cur_b) bus.b_dout <= bus.sd_dout;
          else       bus.a_dout <= bus.sd_dout;
        end
      end
    end
  end
endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed bench for sdram_req_arbiter with a small behavioural SDRAM controller model.
module tb_sdram_req_arbiter;
  localparam int ADDR_W      = 25;
  localparam int INIT_CYCLES = 4;
  localparam int GAP_CYCLES  = 1;

  logic clk;
  logic reset_n;
  logic boot_ok;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_both = 0;

  sdram_req_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  sdram_req_arbiter #(
    .ADDR_W(ADDR_W), .INIT_CYCLES(INIT_CYCLES), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.sd_rd && bus.sd_we) n_both <= n_both + 1;

  // Controller model: lat==0 is a same-word hit (ready stays high, byte select moves one
  // edge after the strobe); otherwise ready drops one edge later and returns lat cycles after that.
  int         m_lat = 1;
  logic [7:0] m_data = 8'h00;
  logic       mdl_ready = 1'b1;
  logic [7:0] mdl_dout = 8'h00;
  logic       mdl_busy = 1'b0;
  int         mdl_cnt = 0;
  logic       strb_q = 1'b0;

  assign bus.sd_ready = mdl_ready && boot_ok;
  assign bus.sd_dout  = mdl_dout;

  always @(posedge clk) begin
    strb_q <= bus.sd_rd | bus.sd_we;
    if (mdl_busy) begin
      if (mdl_cnt == 0) mdl_ready <= 1'b0;
      else if (mdl_cnt == m_lat) begin
        mdl_ready <= 1'b1;
        mdl_dout  <= m_data;
        mdl_busy  <= 1'b0;
      end
      mdl_cnt <= mdl_cnt + 1;
    end else if ((bus.sd_rd | bus.sd_we) && !strb_q) begin
      if (m_lat == 0) mdl_dout <= m_data;
      else begin
        mdl_busy <= 1'b1;
        mdl_cnt  <= 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One request on one port; returns strobe start cycle, count of correct strobe cycles,
  // ack cycle, data seen at ack, and a count of protocol violations.
  task automatic run_xact(input bit port, input bit we, input logic [ADDR_W-1:0] addr,
                          input logic [7:0] din, input int lat, input logic [7:0] rdata,
                          output int t_strobe, output int n_strobe, output int t_ack,
                          output logic [7:0] dout, output int n_wrong);
    logic ack_this, ack_other, good;
    m_lat = lat;
    m_data = rdata;
    t_strobe = -1; n_strobe = 0; t_ack = -1; n_wrong = 0; dout = 8'hxx;
    if (port) begin
      bus.b_we = we; bus.b_addr = addr; bus.b_din = din; bus.b_req = 1'b1;
    end else begin
      bus.a_we = we; bus.a_addr = addr; bus.a_din = din; bus.a_req = 1'b1;
    end
    for (int i = 0; i < 40 && t_strobe < 0; i++) begin
      @(negedge clk);
      if (bus.sd_rd || bus.sd_we) t_strobe = cyc;
    end
    // inputs change after grant; the latched request must not follow them
    if (port) begin
      bus.b_we = ~we; bus.b_addr = ~addr; bus.b_din = ~din;
    end else begin
      bus.a_we = ~we; bus.a_addr = ~addr; bus.a_din = ~din;
    end
    for (int i = 0; i < 60 && t_ack < 0; i++) begin
      ack_this  = port ? bus.b_ack : bus.a_ack;
      ack_other = port ? bus.a_ack : bus.b_ack;
      if (ack_other) n_wrong++;
      if (ack_this) begin
        t_ack = cyc;
        dout  = port ? bus.b_dout : bus.a_dout;
        if (bus.sd_rd || bus.sd_we) n_wrong++;
      end else begin
        good = we ? (bus.sd_we && !bus.sd_rd) : (bus.sd_rd && !bus.sd_we);
        if (good && bus.sd_addr == addr && (!we || bus.sd_din == din)) n_strobe++;
        @(negedge clk);
      end
    end
    if (port) bus.b_req = 1'b0;
    else      bus.a_req = 1'b0;
    @(negedge clk);
    if (bus.a_ack || bus.b_ack) n_wrong++;
  endtask

  typedef struct {
    bit              port;
    bit              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]      din;
    int              lat;
    logic [7:0]      rdata;
    int              exp_strobe;
    int              exp_ack;
    logic [7:0]      exp_dout;
    logic [7:0]      exp_other;
  } vec_t;

  initial begin
    vec_t       vecs[6];
    int         exp_order[4];
    int         ts, ns, ta, nw, prev_ta, cyc0, n_init, n_early, who;
    logic [7:0] dv;
    bit         seen;

    //            port  we    addr            din    lat rdata  strb ack  dout   other
    vecs[0] = '{1'b0, 1'b1, 25'h0000123, 8'h5A, 6, 8'hEE, 9,  9,  8'h91, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 25'h1000001, 8'h00, 8, 8'hC3, 11, 11, 8'hC3, 8'h91};
    vecs[2] = '{1'b0, 1'b0, 25'h0000200, 8'h00, 3, 8'h66, 6,  6,  8'h66, 8'hC3};
    vecs[3] = '{1'b0, 1'b0, 25'h0000201, 8'h00, 0, 8'h77, 3,  3,  8'h77, 8'hC3};
    vecs[4] = '{1'b0, 1'b0, 25'h1FFFFFF, 8'h00, 2, 8'hE1, 5,  5,  8'hE1, 8'hC3};
    vecs[5] = '{1'b1, 1'b1, 25'h00ABCDE, 8'h3C, 1, 8'hEE, 4,  4,  8'hC3, 8'hE1};
    exp_order = '{0, 1, 0, 1};

    reset_n = 1'b0; boot_ok = 1'b0;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_din = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_din = '0;

    // ---- reset values and boot sequence ----
    repeat (3) @(negedge clk);
    check("rst_init", 32'(bus.sd_init), 32'd1);
    check("rst_strobe_ack", 32'({bus.sd_rd, bus.sd_we, bus.a_ack, bus.b_ack}), 32'd0);
    check("rst_sd_addr", 32'(bus.sd_addr), 32'd0);
    check("rst_sd_din", 32'(bus.sd_din), 32'd0);
    check("rst_dout", 32'({bus.a_dout, bus.b_dout}), 32'd0);
    reset_n = 1'b1;
    cyc0 = cyc; n_init = 0; n_early = 0;
    for (int c = 0; c <= 20; c++) begin
      if (bus.sd_init) n_init++;
      if (bus.sd_rd || bus.sd_we || bus.a_ack || bus.b_ack) n_early++;
      if (c == 10) begin
        bus.a_we = 1'b0; bus.a_addr = 25'h00000AA; bus.a_req = 1'b1;
      end
      if (c < 20) @(negedge clk);
    end
    boot_ok = 1'b1;
    check("boot_init_cycles", 32'(n_init), 32'(INIT_CYCLES));
    check("boot_no_early_service", 32'(n_early), 32'd0);
    run_xact(1'b0, 1'b0, 25'h00000AA, 8'h00, 2, 8'h91, ts, ns, ta, dv, nw);
    check("boot_strobe_not_before_21", 32'(ts - cyc0 >= 21), 32'd1);
    check("boot_ack_latency", 32'(ta - ts), 32'd5);
    check("boot_dout", 32'(dv), 32'h91);
    check("boot_protocol", 32'(nw), 32'd0);
    prev_ta = ta;

    // ---- table of single transactions ----
    for (int i = 0; i < 6; i++) begin
      run_xact(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].lat, vecs[i].rdata,
               ts, ns, ta, dv, nw);
      check($sformatf("v%0d_strobe_cycles", i), 32'(ns), 32'(vecs[i].exp_strobe));
      check($sformatf("v%0d_ack_latency", i), 32'(ta - ts), 32'(vecs[i].exp_ack));
      check($sformatf("v%0d_dout", i), 32'(dv), 32'(vecs[i].exp_dout));
      check($sformatf("v%0d_other_dout", i),
            32'(vecs[i].port ? bus.a_dout : bus.b_dout), 32'(vecs[i].exp_other));
      check($sformatf("v%0d_protocol", i), 32'(nw), 32'd0);
      // strobe low through GAP plus the IDLE arbitration cycle
      check($sformatf("v%0d_strobe_gap", i), 32'(ts - prev_ta), 32'(GAP_CYCLES + 1));
      prev_ta = ta;
    end

    // ---- contention: both ports held, round-robin order ----
    m_lat = 2; m_data = 8'h4D;
    bus.a_we = 1'b1; bus.a_addr = 25'h0000010; bus.a_din = 8'h11;
    bus.b_we = 1'b0; bus.b_addr = 25'h0000020; bus.b_din = 8'h00;
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      who = -1;
      for (int j = 0; j < 30 && who < 0; j++) begin
        @(negedge clk);
        if (bus.a_ack) who = 0;
        else if (bus.b_ack) who = 1;
      end
      check($sformatf("rr_grant%0d", i), 32'(who), 32'(exp_order[i]));
      if (who == 0) bus.a_req = 1'b0;
      else if (who == 1) bus.b_req = 1'b0;
      @(negedge clk);
      bus.a_req = 1'b1; bus.b_req = 1'b1;
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    check("rr_b_dout", 32'(bus.b_dout), 32'h4D);
    check("strobes_exclusive", 32'(n_both), 32'd0);

    // ---- reset during HOLD of a write ----
    repeat (3) @(negedge clk);
    m_lat = 4; m_data = 8'hEE;
    bus.a_we = 1'b1; bus.a_addr = 25'h0000777; bus.a_din = 8'hA5; bus.a_req = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 10 && !seen; j++) begin
      @(negedge clk);
      seen = bus.sd_we;
    end
    check("mr_strobe_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check("mr_we_in_hold", 32'(bus.sd_we), 32'd1);
    reset_n = 1'b0; boot_ok = 1'b0;
    #1;
    check("mr_we_drops_async", 32'(bus.sd_we), 32'd0);
    check("mr_init_async", 32'(bus.sd_init), 32'd1);
    n_early = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.a_ack || bus.b_ack) n_early++;
    end
    reset_n = 1'b1;
    n_init = 0;
    for (int c = 0; c <= 11; c++) begin
      if (bus.sd_init) n_init++;
      if (bus.sd_rd || bus.sd_we || bus.a_ack || bus.b_ack) n_early++;
      if (c < 11) @(negedge clk);
    end
    check("mr_init_cycles", 32'(n_init), 32'(INIT_CYCLES));
    check("mr_no_ack_no_service", 32'(n_early), 32'd0);
    boot_ok = 1'b1;
    run_xact(1'b0, 1'b1, 25'h0000777, 8'hA5, 2, 8'hEE, ts, ns, ta, dv, nw);
    check("mr_resume_strobe_cycles", 32'(ns), 32'd5);
    check("mr_resume_ack_latency", 32'(ta - ts), 32'd5);
    check("mr_resume_protocol", 32'(nw), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
